// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection among sequential/branch, JALR,
// trap and MRET paths, including misaligned-target suppression and a trap bubble.
module pc_next_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] pcsrc_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  localparam int ALIGN_BITS = (IALIGN == 2) ? 1 : 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

  // Handshake: none. Every request input is a level sampled at each rising edge
  // while in RUN; a request that is ignored (BOOT, FLUSH, or lower priority) is lost.

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state;

  logic [XLEN-1:0] candidate;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] epc_pc;
  logic            cand_misaligned;

  always_comb begin
    candidate       = pcsrc_target;
    if (jalr) candidate = {jalr_target[XLEN-1:1], 1'b0};
    cand_misaligned = |candidate[ALIGN_BITS-1:0];
    trap_pc         = trap_vec & ALIGN_MASK;
    epc_pc          = epc & ALIGN_MASK;
  end

  // pc_valid is registered alongside the state so it is high exactly in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (trap_req) begin
            pc       <= trap_pc;
            state    <= FLUSH;
            pc_valid <= 1'b0;
          end else if (stall) begin
            pc <= pc;
          end else if (mret) begin
            pc <= epc_pc;
          end else if (cand_misaligned) begin
            pc            <= trap_pc;
            misalign      <= 1'b1;
            misalign_addr <= candidate;
            state         <= FLUSH;
            pc_valid      <= 1'b0;
          end else begin
            pc <= candidate;
          end
        end
        FLUSH: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: table of per-edge vectors on an IALIGN=4 instance,
// plus hand-written async-reset and IALIGN=2 sequences.
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jalr;
  logic [31:0] jalr_target;
  logic [31:0] pcsrc_target;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] epc;

  logic [31:0] pc4, pc2, ma4, ma2;
  logic        v4, v2, m4, m2;

  int errors = 0;
  int checks = 0;

  pc_next_unit #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jalr(jalr), .jalr_target(jalr_target),
    .pcsrc_target(pcsrc_target), .trap_req(trap_req), .trap_vec(trap_vec), .mret(mret),
    .epc(epc), .pc(pc4), .pc_valid(v4), .misalign(m4), .misalign_addr(ma4)
  );

  pc_next_unit #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jalr(jalr), .jalr_target(jalr_target),
    .pcsrc_target(pcsrc_target), .trap_req(trap_req), .trap_vec(trap_vec), .mret(mret),
    .epc(epc), .pc(pc2), .pc_valid(v2), .misalign(m2), .misalign_addr(ma2)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  typedef struct {
    logic        stall;
    logic        jalr;
    logic [31:0] jt;
    logic [31:0] pt;
    logic        trap;
    logic [31:0] tv;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_m;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic s, logic j, logic [31:0] jt, logic [31:0] pt,
                              logic t, logic [31:0] tv, logic m, logic [31:0] e,
                              logic [31:0] e_pc, logic e_v, logic e_m, logic [31:0] e_ma);
    vec_t r;
    r.stall = s; r.jalr = j; r.jt = jt; r.pt = pt; r.trap = t; r.tv = tv;
    r.mret = m; r.epc = e; r.e_pc = e_pc; r.e_v = e_v; r.e_m = e_m; r.e_ma = e_ma;
    return r;
  endfunction

  // scoreboard
  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check4(input int idx, input logic [31:0] e_pc, input logic e_v,
                        input logic e_m, input logic [31:0] e_ma);
    check("pc", idx, pc4, e_pc);
    check("pc_valid", idx, {31'b0, v4}, {31'b0, e_v});
    check("misalign", idx, {31'b0, m4}, {31'b0, e_m});
    check("misalign_addr", idx, ma4, e_ma);
  endtask

  task automatic check2(input int idx, input logic [31:0] e_pc, input logic e_v,
                        input logic e_m, input logic [31:0] e_ma);
    check("pc_ia2", idx, pc2, e_pc);
    check("pc_valid_ia2", idx, {31'b0, v2}, {31'b0, e_v});
    check("misalign_ia2", idx, {31'b0, m2}, {31'b0, e_m});
    check("misalign_addr_ia2", idx, ma2, e_ma);
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic j, input logic [31:0] jt,
                       input logic [31:0] pt, input logic t, input logic [31:0] tv,
                       input logic m, input logic [31:0] e);
    stall = s; jalr = j; jalr_target = jt; pcsrc_target = pt;
    trap_req = t; trap_vec = tv; mret = m; epc = e;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 32'h0000_0303, 32'hDEAD_0000, 1, 32'h0000_0400, 1, 32'h0000_0500, 32'h100, 1, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,         32'h0000_0104, 0, 32'h0000_0080, 0, 32'h0,         32'h104, 1, 0, 32'h0);
    vecs[2]  = mk(0, 1, 32'h0000_0201, 32'h0000_0999, 0, 32'h0000_0080, 0, 32'h0,         32'h200, 1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,         32'h0000_1002, 0, 32'h0000_0080, 0, 32'h0,         32'h080, 0, 1, 32'h1002);
    vecs[4]  = mk(1, 0, 32'h0,         32'h0000_2000, 1, 32'h0000_0900, 0, 32'h0,         32'h080, 1, 0, 32'h1002);
    vecs[5]  = mk(0, 0, 32'h0,         32'h0000_0084, 0, 32'h0000_0080, 0, 32'h0,         32'h084, 1, 0, 32'h1002);
    vecs[6]  = mk(1, 1, 32'h0000_0300, 32'h0000_0088, 0, 32'h0000_0080, 0, 32'h0,         32'h084, 1, 0, 32'h1002);
    vecs[7]  = mk(1, 1, 32'h0000_0300, 32'h0000_0088, 0, 32'h0000_0080, 1, 32'h0000_0500, 32'h084, 1, 0, 32'h1002);
    vecs[8]  = mk(1, 0, 32'h0,         32'h0000_0088, 1, 32'h0000_0043, 0, 32'h0,         32'h040, 0, 0, 32'h1002);
    vecs[9]  = mk(0, 0, 32'h0,         32'h0000_0044, 0, 32'h0000_0043, 0, 32'h0,         32'h040, 1, 0, 32'h1002);
    vecs[10] = mk(0, 1, 32'h0000_0600, 32'h0000_0044, 1, 32'h0000_0200, 1, 32'h0000_0555, 32'h200, 0, 0, 32'h1002);
    vecs[11] = mk(0, 0, 32'h0,         32'h0000_0204, 0, 32'h0000_0200, 0, 32'h0,         32'h200, 1, 0, 32'h1002);
    vecs[12] = mk(0, 1, 32'h0000_0600, 32'h0000_0208, 0, 32'h0000_0200, 1, 32'h0000_0555, 32'h554, 1, 0, 32'h1002);
    vecs[13] = mk(0, 1, 32'h0000_0603, 32'h0000_0558, 0, 32'h0000_0080, 0, 32'h0,         32'h080, 0, 1, 32'h602);
    vecs[14] = mk(0, 0, 32'h0,         32'h0000_0084, 0, 32'h0000_0080, 0, 32'h0,         32'h080, 1, 0, 32'h602);
    vecs[15] = mk(0, 0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0000_0080, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 32'h602);
    vecs[16] = mk(0, 0, 32'h0,         32'h0000_0003, 0, 32'h0000_000C, 0, 32'h0,         32'h00C, 0, 1, 32'h3);
    vecs[17] = mk(0, 0, 32'h0,         32'h0000_0010, 0, 32'h0000_000C, 0, 32'h0,         32'h00C, 1, 0, 32'h3);

    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check4(100, 32'h100, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check4(101, 32'h100, 0, 0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].jalr, vecs[i].jt, vecs[i].pt,
            vecs[i].trap, vecs[i].tv, vecs[i].mret, vecs[i].epc);
      step();
      check4(i, vecs[i].e_pc, vecs[i].e_v, vecs[i].e_m, vecs[i].e_ma);
    end

    // misaligned redirect, then async reset in the middle of the FLUSH cycle
    drive(0, 0, 32'h0, 32'h0000_1001, 0, 32'h0000_0080, 0, 32'h0);
    step();
    check4(200, 32'h080, 0, 1, 32'h1001);
    #3 rst_n = 1'b0;
    #1;
    check4(201, 32'h100, 0, 0, 32'h0);
    check2(201, 32'h100, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 32'h0000_0104, 0, 32'h0000_0083, 0, 32'h0);
    step();
    check2(202, 32'h100, 1, 0, 32'h0);

    // IALIGN=2: cleared JALR target and halfword targets are legal
    drive(0, 1, 32'h0000_0203, 32'h0000_0104, 0, 32'h0000_0083, 0, 32'h0);
    step();
    check2(203, 32'h202, 1, 0, 32'h0);
    drive(0, 0, 32'h0, 32'h0000_1002, 0, 32'h0000_0083, 0, 32'h0);
    step();
    check2(204, 32'h1002, 1, 0, 32'h0);
    drive(0, 0, 32'h0, 32'h0000_1001, 0, 32'h0000_0083, 0, 32'h0);
    step();
    check2(205, 32'h082, 0, 1, 32'h1001);
    drive(0, 0, 32'h0, 32'h0000_1004, 0, 32'h0000_0083, 1, 32'h0000_0555);
    step();
    check2(206, 32'h082, 1, 0, 32'h1001);
    step();
    check2(207, 32'h554, 1, 0, 32'h1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
